// File: rtl/sfr_mon.sv
// Tile SFR block: ID/ctrl/IRQ-enable/SGI registers, interval timers and a circular bus trace buffer.
// Optional SFR_MON_TIMESTAMP_EN builds a 16-bit free-running cycle counter stamped into trace word 2.
module sfr_mon #(
  parameter logic [31:0] CORENUM          = 32'd0,
  parameter bit          SW_RESET_DEFAULT = 1'b0,
  parameter int unsigned IRQ_NUM_POW      = 4,
  parameter int unsigned TIMER_NUM        = 2,
  parameter int unsigned TRACE_DEPTH_POW  = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        host_req_i,
  output logic                        host_ack_o,
  input  logic                        host_we_i,
  input  logic [31:0]                 host_addr_bi,
  input  logic [31:0]                 host_wdata_bi,
  output logic                        host_resp_o,
  output logic [31:0]                 host_rdata_bo,
  output logic                        sw_reset_o,
  output logic [(1<<IRQ_NUM_POW)-1:0] irq_en_bo,
  output logic [TIMER_NUM-1:0]        irq_timer_bo,
  output logic                        sgi_req_o,
  output logic [IRQ_NUM_POW-1:0]      sgi_code_bo
);

  localparam int unsigned IRQN  = 1 << IRQ_NUM_POW;
  localparam int unsigned DEPTH = 1 << TRACE_DEPTH_POW;
  localparam int unsigned PW    = TRACE_DEPTH_POW;

  typedef enum logic [1:0] {T_OFF, T_RUN, T_FULL} trc_st_e;

  logic [7:0] aw;
  logic       rd_en, wr_en, tmr_sel;
  assign aw      = {host_addr_bi[7:2], 2'b00};
  assign rd_en   = host_req_i & ~host_we_i;
  assign wr_en   = host_req_i & host_we_i;
  assign tmr_sel = (aw[7:5] == 3'b001);

  assign host_ack_o = host_req_i;

  logic            resp_q, sw_reset_q, autoclr_q, sw_reset_o_q, sgi_req_q;
  logic [31:0]     rdata_q, rdata_d;
  logic [IRQN-1:0] irq_en_q;
  logic [IRQ_NUM_POW-1:0] sgi_code_q;

  logic [31:0]          tmr_val_q [TIMER_NUM];
  logic [31:0]          tmr_per_q [TIMER_NUM];
  logic [TIMER_NUM-1:0] tmr_run_q, tmr_rld_q, tmr_irq_q;

  trc_st_e         st_q, st_d;
  logic            trc_en_q, trc_wrap_q, ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [95:0]     mem [DEPTH];
  logic [95:0]     head, entry;
  logic            mem_we;

  logic            pend_vld_q, pend_we_q;
  logic [31:0]     pend_addr_q, pend_wdata_q;
  logic [15:0]     pend_ts_q, ts;

`ifdef SFR_MON_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ts_q <= '0;
    else        ts_q <= ts_q + 16'd1;
  end
  assign ts = ts_q;
`else
  assign ts = '0;
`endif

  assign head = mem[rd_ptr_q];

  always_comb begin
    rdata_d = '0;
    case (aw)
      8'h00: rdata_d = 32'hDEAD_BEEF;
      8'h04: rdata_d = {30'b0, autoclr_q, sw_reset_q};
      8'h08: rdata_d = CORENUM;
      8'h10: rdata_d = 32'(irq_en_q);
      8'h80: rdata_d = {30'b0, trc_wrap_q, trc_en_q};
      8'h84: rdata_d = {ovf_q, 15'b0, 16'(cnt_q)};
      8'h90: rdata_d = (cnt_q != '0) ? head[95:64] : '0;
      8'h94: rdata_d = (cnt_q != '0) ? head[63:32] : '0;
      8'h98: rdata_d = (cnt_q != '0) ? head[31:0]  : '0;
      default: rdata_d = '0;
    endcase
    for (int unsigned k = 0; k < TIMER_NUM; k++) begin
      if (tmr_sel && aw[4:3] == 2'(k))
        rdata_d = aw[2] ? tmr_per_q[k] : {30'b0, tmr_rld_q[k], tmr_run_q[k]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_q       <= 1'b0;
      rdata_q      <= '0;
      sw_reset_q   <= SW_RESET_DEFAULT;
      autoclr_q    <= 1'b0;
      sw_reset_o_q <= 1'b1;
      irq_en_q     <= '0;
      sgi_req_q    <= 1'b0;
      sgi_code_q   <= '0;
    end else begin
      resp_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
      if (wr_en && aw == 8'h04) begin
        sw_reset_q <= host_wdata_bi[0];
        autoclr_q  <= host_wdata_bi[1];
      end else if (sw_reset_q && autoclr_q) begin
        sw_reset_q <= 1'b0;
      end
      sw_reset_o_q <= sw_reset_q;
      if (wr_en && aw == 8'h10) irq_en_q <= host_wdata_bi[IRQN-1:0];
      sgi_req_q <= wr_en && aw == 8'h14;
      if (wr_en && aw == 8'h14) sgi_code_q <= host_wdata_bi[IRQ_NUM_POW-1:0];
    end
  end

  // A CTRL write in the expiry cycle restarts the channel and suppresses that pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmr_run_q <= '0;
      tmr_rld_q <= '0;
      tmr_irq_q <= '0;
      for (int unsigned k = 0; k < TIMER_NUM; k++) begin
        tmr_val_q[k] <= '0;
        tmr_per_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < TIMER_NUM; k++) begin
        tmr_irq_q[k] <= 1'b0;
        if (sw_reset_o_q) begin
          tmr_run_q[k] <= 1'b0;
          tmr_rld_q[k] <= 1'b0;
          tmr_val_q[k] <= '0;
          tmr_per_q[k] <= '0;
        end else begin
          if (wr_en && tmr_sel && aw[4:3] == 2'(k) && !aw[2]) begin
            tmr_val_q[k] <= '0;
            tmr_run_q[k] <= host_wdata_bi[0];
            tmr_rld_q[k] <= host_wdata_bi[1];
          end else if (tmr_run_q[k]) begin
            if (tmr_val_q[k] == tmr_per_q[k]) begin
              tmr_irq_q[k] <= 1'b1;
              tmr_val_q[k] <= '0;
              tmr_run_q[k] <= tmr_rld_q[k];
            end else begin
              tmr_val_q[k] <= tmr_val_q[k] + 32'd1;
            end
          end
          if (wr_en && tmr_sel && aw[4:3] == 2'(k) && aw[2])
            tmr_per_q[k] <= host_wdata_bi;
        end
      end
    end
  end

  // Every logged access is pushed one cycle after its request, so a read (pushed in its
  // resp cycle) and a following write never collide on the single write port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_vld_q   <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_ts_q    <= '0;
    end else begin
      pend_vld_q <= host_req_i && (aw[7:5] != 3'b100);
      if (host_req_i) begin
        pend_we_q    <= host_we_i;
        pend_addr_q  <= host_addr_bi;
        pend_wdata_q <= host_wdata_bi;
        pend_ts_q    <= ts;
      end
    end
  end

  assign entry = {pend_addr_q, pend_we_q ? pend_wdata_q : rdata_q, pend_we_q, 15'b0, pend_ts_q};

  always_comb begin
    st_d     = st_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    if (wr_en && aw == 8'h9C && cnt_q != '0) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d    = cnt_q - 1'b1;
      if (st_q == T_FULL) st_d = T_RUN;
    end
    if (pend_vld_q) begin
      if (st_d == T_RUN) begin
        if (cnt_d == (PW+1)'(DEPTH)) begin
          ovf_d = 1'b1;
          if (trc_wrap_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d = rd_ptr_d + PW'(1);
          end else begin
            st_d = T_FULL;
          end
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          cnt_d    = cnt_d + 1'b1;
        end
      end else if (st_d == T_FULL) begin
        ovf_d = 1'b1;
      end
    end
    if (wr_en && aw == 8'h80) begin
      if (!host_wdata_bi[0])  st_d = T_OFF;
      else if (st_q == T_OFF) st_d = T_RUN;
      if (host_wdata_bi[2]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        mem_we   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q       <= T_OFF;
      trc_en_q   <= 1'b0;
      trc_wrap_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      st_q     <= st_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (wr_en && aw == 8'h80) begin
        trc_en_q   <= host_wdata_bi[0];
        trc_wrap_q <= host_wdata_bi[1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= entry;
  end

  assign host_resp_o   = resp_q;
  assign host_rdata_bo = rdata_q;
  assign sw_reset_o    = sw_reset_o_q;
  assign irq_en_bo     = irq_en_q;
  assign irq_timer_bo  = tmr_irq_q;
  assign sgi_req_o     = sgi_req_q;
  assign sgi_code_bo   = sgi_code_q;

endmodule
